rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource between requesters. It uses a registered grant FSM with a bounded hold time. The winning 2-bit index is decoded to a one-hot grant vector, so downstream logic can use either the index or the one-hot form. It sits between the requester ports and the shared resource; the resource sees exactly one active grant or none.

---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_arbiter4_if.sv | 22 ++
 rtl/grant_decoder2x4.sv | 15 +
 rtl/rr_arbiter4.sv | 78 +++++++
 tb/tb_rr_arbiter4.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ            = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Requester-side bus of rr_arbiter4: enable, requests and grant outputs.
interface rr_arbiter4_if;
  import rr_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/grant_decoder2x4.sv
// One-hot decode of the registered grant index, gated by the GRANT state.
module grant_decoder2x4
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (en_i) gnt_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a bounded grant hold time.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] winner_d;

  // Rotate so bit 0 is the requester just after last, pick the lowest set bit, rotate back.
  always_comb begin
    logic [IDX_W-1:0] src;
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      src        = last_q + IDX_W'(1) + IDX_W'(i);
      req_rot[i] = bus.req[src];
    end
    winner_d = last_q + IDX_W'(1) + first_set(req_rot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en && (|bus.req)) begin
            state_q    <= GRANT;
            gnt_idx_q  <= winner_d;
            last_q     <= winner_d;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else if (!bus.req[gnt_idx_q]) begin
            state_q <= IDLE;
          end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  grant_decoder2x4 u_dec (
    .idx_i (gnt_idx_q),
    .en_i  (state_q == GRANT),
    .gnt_o (bus.gnt)
  );

  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=8; outputs sampled on the falling edge.
module tb_rr_arbiter4;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(
    .MAX_HOLD (8),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
    chk_eq({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    chk_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'(|exp_gnt));
    chk_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(exp_to));
    if (exp_gnt != 4'b0000)
      chk_eq({tag, ".idx"}, 32'(bus.gnt_idx), 32'(oh_to_idx(exp_gnt)));
  endtask

  task automatic hold(input string tag, input logic [3:0] exp_gnt, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check_out($sformatf("%s.hold%0d", tag, k), exp_gnt, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] e;

    bus.en  = 1'b1;
    bus.req = 4'b0000;
    rst_n   = 1'b0;
    step();
    step();
    check_out("reset", 4'b0000, 1'b0);
    chk_eq("reset.idx", 32'(bus.gnt_idx), 32'd0);

    // First grant plus full rotation 0,1,2,3,0, each timing out after 8 cycles
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      step();
      check_out($sformatf("rot%0d.entry", g), e, 1'b0);
      hold($sformatf("rot%0d", g), e, 7);
      step();
      check_out($sformatf("rot%0d.tmo", g), 4'b0000, 1'b1);
    end

    // Skip and wrap
    bus.req = 4'b0100;
    step();
    check_out("wrap.g2", 4'b0100, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("wrap.rel2", 4'b0000, 1'b0);
    bus.req = 4'b0011;
    step();
    check_out("wrap.g0", 4'b0001, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("wrap.rel0", 4'b0000, 1'b0);
    bus.req = 4'b0011;
    step();
    check_out("wrap.g1", 4'b0010, 1'b0);

    // Early release after 3 cycles, then full-length hold proves the counter restarted
    hold("early", 4'b0010, 2);
    bus.req = 4'b0000;
    step();
    check_out("early.rel", 4'b0000, 1'b0);
    bus.req = 4'b0010;
    step();
    check_out("early.regnt", 4'b0010, 1'b0);
    hold("early.re", 4'b0010, 7);
    step();
    check_out("early.tmo", 4'b0000, 1'b1);

    // Enable gating and en drop colliding with hold_cnt=7
    bus.en  = 1'b0;
    bus.req = 4'b0100;
    step();
    check_out("en.off0", 4'b0000, 1'b0);
    step();
    check_out("en.off1", 4'b0000, 1'b0);
    bus.en = 1'b1;
    step();
    check_out("en.on", 4'b0100, 1'b0);
    hold("en", 4'b0100, 7);
    bus.en = 1'b0;
    step();
    check_out("en.collide", 4'b0000, 1'b0);
    step();
    check_out("en.stay", 4'b0000, 1'b0);

    // Release colliding with hold_cnt=7
    bus.en = 1'b1;
    step();
    check_out("relcol.g2", 4'b0100, 1'b0);
    hold("relcol", 4'b0100, 7);
    bus.req = 4'b0000;
    step();
    check_out("relcol.rel", 4'b0000, 1'b0);

    // Other requests do not pre-empt an active grant
    bus.req = 4'b0001;
    step();
    check_out("nopre.g0", 4'b0001, 1'b0);
    bus.req = 4'b1111;
    step();
    check_out("nopre.keep0", 4'b0001, 1'b0);
    step();
    check_out("nopre.keep1", 4'b0001, 1'b0);
    bus.req = 4'b1000;
    step();
    check_out("nopre.rel", 4'b0000, 1'b0);
    step();
    check_out("nopre.g3", 4'b1000, 1'b0);

    // Reset mid-grant, request held through reset
    rst_n   = 1'b0;
    bus.req = 4'b1001;
    step();
    check_out("midrst.rst", 4'b0000, 1'b0);
    chk_eq("midrst.idx", 32'(bus.gnt_idx), 32'd0);
    rst_n = 1'b1;
    step();
    check_out("midrst.g0", 4'b0001, 1'b0);

    // last must return to 3 on reset even when it was 1
    bus.req = 4'b0010;
    step();
    check_out("lastrst.rel", 4'b0000, 1'b0);
    step();
    check_out("lastrst.g1", 4'b0010, 1'b0);
    rst_n   = 1'b0;
    bus.req = 4'b0110;
    step();
    check_out("lastrst.rst", 4'b0000, 1'b0);
    rst_n = 1'b1;
    step();
    check_out("lastrst.g1b", 4'b0010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
